// File: rtl/fft8_pkg.sv
// Shared constants, complex-word type and bit-reversal helper for the FFT8 output streamer.
package fft8_pkg;
  localparam int DW         = 32;
  localparam int NPT        = 8;
  localparam int LOG2N      = 3;
  localparam int FP_EXP_MSB = 30;
  localparam int FP_EXP_LSB = 23;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction
endpackage

// File: rtl/fft8_output_streamer_if.sv
// Frame-in / bin-out handshake bundle of the FFT8 output streamer.
interface fft8_output_streamer_if;
  import fft8_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [NPT*DW-1:0]    in_real;
  logic [NPT*DW-1:0]    in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_real;
  logic [DW-1:0]        out_imag;
  logic [LOG2N-1:0]     out_index;
  logic                 out_last;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last
  );
endinterface

// File: rtl/fft8_fp_scale.sv
// Divides one IEEE-754 single by NPT via exponent subtraction; inf/NaN pass, underflow flushes to signed zero.
module fft8_fp_scale
  import fft8_pkg::*;
(
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [7:0] exp_in;

  assign exp_in = din[FP_EXP_MSB:FP_EXP_LSB];

  always_comb begin
    dout = din;
    if (exp_in == FP_EXP_MAX) begin
      dout = din;
    end else if (exp_in <= 8'(LOG2N)) begin
      dout = {din[DW-1], {(DW-1){1'b0}}};
    end else begin
      dout[FP_EXP_MSB:FP_EXP_LSB] = exp_in - 8'(LOG2N);
    end
  end
endmodule

// File: rtl/fft8_output_streamer.sv
// Ping-pong buffered bit-reversed-to-natural reorder and serialiser for 8-point FFT frames.
// Optional 1/NPT output scaling is enabled by defining FFT8_SCALE_EN.
module fft8_output_streamer
  import fft8_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  fft8_output_streamer_if.slave  bus
);
  cplx_t            bank_q [2][NPT];
  cplx_t            bank_d [2][NPT];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             beat;
  logic             last_bin;
  cplx_t            rd_word;
  logic [DW-1:0]    re_out;
  logic [DW-1:0]    im_out;

  // Handshake flags depend on registered state only, so in_ready never sees out_ready.
  assign bus.in_ready  = !rst && !full_q[wr_bank_q];
  assign bus.out_valid = !rst && full_q[rd_bank_q];
  assign accept        = bus.in_valid && bus.in_ready;
  assign beat          = bus.out_valid && bus.out_ready;
  assign last_bin      = (cnt_q == LOG2N'(NPT - 1));

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    cnt_d     = cnt_q;
    if (accept) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    // An accepting bank is always empty and a draining bank is always full, so both may fire together.
    if (beat) begin
      cnt_d = cnt_q + LOG2N'(1);
      if (last_bin) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (accept) begin
      for (int k = 0; k < NPT; k++) begin
        bank_d[wr_bank_q][k].re = bus.in_real[k*DW +: DW];
        bank_d[wr_bank_q][k].im = bus.in_imag[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  // Slot k of a stored frame holds bin bitrev(k), so natural bin cnt lives at slot bitrev(cnt).
  assign rd_word = bank_q[rd_bank_q][bitrev3(cnt_q)];

`ifdef FFT8_SCALE_EN
  fft8_fp_scale u_scale_re (
    .din  (rd_word.re),
    .dout (re_out)
  );

  fft8_fp_scale u_scale_im (
    .din  (rd_word.im),
    .dout (im_out)
  );
`else
  assign re_out = rd_word.re;
  assign im_out = rd_word.im;
`endif

  always_comb begin
    bus.out_real  = '0;
    bus.out_imag  = '0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    if (bus.out_valid) begin
      bus.out_real  = re_out;
      bus.out_imag  = im_out;
      bus.out_index = cnt_q;
      bus.out_last  = last_bin;
    end
  end
endmodule
